// File: rtl/adb_pkg.sv
// Shared encodings for the ADB host sequencer: transceiver st codes, opcodes,
// default timing constants, the sequencer state enum and the command decoder.
package adb_pkg;

  localparam logic [1:0] ST_CMD  = 2'b00;
  localparam logic [1:0] ST_EVEN = 2'b01;
  localparam logic [1:0] ST_ODD  = 2'b10;
  localparam logic [1:0] ST_IDLE = 2'b11;

  localparam logic [3:0] OP_RESET  = 4'b0000;
  localparam logic [3:0] OP_FLUSH  = 4'b0001;
  localparam logic [1:0] OP_LISTEN = 2'b10;
  localparam logic [1:0] OP_TALK   = 2'b11;

  localparam logic [16:0] DEF_POLL_INTERVAL = 17'd88000;
  localparam logic [7:0]  DEF_SETTLE        = 8'd64;
  localparam logic [15:0] DEF_BYTE_TIMEOUT  = 16'd800;
  localparam logic [3:0]  DEF_ADDR_KBD      = 4'd2;
  localparam logic [3:0]  DEF_ADDR_MOUSE    = 4'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_EVEN,
    S_ODD,
    S_LEVEN,
    S_LODD,
    S_DONE
  } seq_state_e;

  // Talk/Reset/Flush expect a response byte, Listen sends data, the rest end at once.
  function automatic seq_state_e cmd_next_state(input logic [3:0] op);
    if (op[3:2] == OP_TALK || op == OP_RESET || op == OP_FLUSH) return S_EVEN;
    if (op[3:2] == OP_LISTEN) return S_LEVEN;
    return S_DONE;
  endfunction

endpackage

// File: rtl/adb_tick_timer.sv
// Loadable down-counter with zero flag; advances only on clk_en ticks and
// saturates at zero.
module adb_tick_timer #(
  parameter int            W         = 8,
  parameter logic [W-1:0]  RESET_VAL = '0
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         clk_en_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= RESET_VAL;
    end else if (clk_en_i) begin
      if (load_i) begin
        count_q <= load_val_i;
      end else if (dec_i && count_q != '0) begin
        count_q <= count_q - W'(1);
      end
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/adb_host_sequencer.sv
// Host-side ADB bus sequencer: arbitrates host commands over keyboard/mouse autopoll.
// Define ADB_SRQ_POLL_EN to let a service request (_int low) trigger an immediate poll.
module adb_host_sequencer
  import adb_pkg::*;
#(
  parameter logic [16:0] POLL_INTERVAL = DEF_POLL_INTERVAL,
  parameter logic [7:0]  SETTLE        = DEF_SETTLE,
  parameter logic [15:0] BYTE_TIMEOUT  = DEF_BYTE_TIMEOUT,
  parameter logic [3:0]  ADDR_KBD      = DEF_ADDR_KBD,
  parameter logic [3:0]  ADDR_MOUSE    = DEF_ADDR_MOUSE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  output logic [1:0]  st,
  output logic        viaBusy,
  output logic [7:0]  adb_din,
  output logic        adb_din_strobe,
  input  logic [7:0]  adb_dout,
  input  logic        adb_dout_strobe,
  input  logic        _int,
  input  logic        host_req,
  input  logic [7:0]  host_cmd,
  input  logic [15:0] host_data,
  output logic        host_ack,
  output logic        resp_valid,
  output logic [15:0] resp_data,
  output logic [1:0]  resp_len,
  output logic        resp_host,
  output logic        resp_timeout
);

  seq_state_e  state_q;
  logic [1:0]  st_q;
  logic        via_busy_q, adb_din_strobe_q, host_ack_q, resp_valid_q;
  logic [7:0]  adb_din_q;
  logic [15:0] resp_data_q, data_q;
  logic [1:0]  resp_len_q;
  logic        resp_host_q, resp_timeout_q;
  logic [3:0]  op_q;
  logic        got_q, target_mouse_q, poll_pend_q, srq_pend_q;

  logic        settle_zero, to_zero, poll_zero;
  logic        in_idle, in_byte, in_listen, poll_due, start, cap, even_adv;
  logic        settle_load, to_load;
  logic [7:0]  cmd_start;
  seq_state_e  cmd_nxt;

  always_comb begin
    in_idle     = (state_q == S_IDLE);
    in_byte     = (state_q == S_EVEN) || (state_q == S_ODD);
    in_listen   = (state_q == S_LEVEN) || (state_q == S_LODD);
    poll_due    = poll_zero | poll_pend_q | srq_pend_q;
    start       = in_idle & (host_req | poll_due);
    cap         = in_byte & ~got_q & adb_dout_strobe;
    even_adv    = (state_q == S_EVEN) & got_q & settle_zero;
    settle_load = start | cap | (in_listen & ~got_q);
    to_load     = ~in_byte | even_adv;
    cmd_start   = host_req ? host_cmd
                           : {(target_mouse_q ? ADDR_MOUSE : ADDR_KBD), OP_TALK, 2'b00};
    cmd_nxt     = cmd_next_state(op_q);
  end

  adb_tick_timer #(.W(8), .RESET_VAL(8'd0)) u_settle (
    .clk_i(clk), .reset_i(reset), .clk_en_i(clk_en),
    .load_i(settle_load), .load_val_i(SETTLE), .dec_i(1'b1), .zero_o(settle_zero)
  );

  adb_tick_timer #(.W(16), .RESET_VAL(16'd0)) u_byte_to (
    .clk_i(clk), .reset_i(reset), .clk_en_i(clk_en),
    .load_i(to_load), .load_val_i(BYTE_TIMEOUT), .dec_i(in_byte & ~got_q), .zero_o(to_zero)
  );

  adb_tick_timer #(.W(17), .RESET_VAL(POLL_INTERVAL)) u_poll (
    .clk_i(clk), .reset_i(reset), .clk_en_i(clk_en),
    .load_i(start), .load_val_i(POLL_INTERVAL), .dec_i(in_idle), .zero_o(poll_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= S_IDLE;
      st_q             <= ST_IDLE;
      via_busy_q       <= 1'b0;
      adb_din_q        <= 8'h00;
      adb_din_strobe_q <= 1'b0;
      host_ack_q       <= 1'b0;
      resp_valid_q     <= 1'b0;
      resp_data_q      <= 16'hFFFF;
      resp_len_q       <= 2'd0;
      resp_host_q      <= 1'b0;
      resp_timeout_q   <= 1'b0;
      op_q             <= 4'h0;
      data_q           <= 16'h0000;
      got_q            <= 1'b0;
      target_mouse_q   <= 1'b0;
      poll_pend_q      <= 1'b0;
      srq_pend_q       <= 1'b0;
    end else if (clk_en) begin
      adb_din_strobe_q <= 1'b0;
      host_ack_q       <= 1'b0;
      resp_valid_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q          <= S_CMD;
            st_q             <= ST_CMD;
            via_busy_q       <= 1'b1;
            adb_din_q        <= cmd_start;
            adb_din_strobe_q <= 1'b1;
            op_q             <= cmd_start[3:0];
            resp_data_q      <= 16'hFFFF;
            resp_len_q       <= 2'd0;
            resp_timeout_q   <= 1'b0;
            resp_host_q      <= host_req;
            if (host_req) begin
              data_q     <= host_data;
              host_ack_q <= 1'b1;
              // timer reloads on this start, so remember a poll that was due
              if (poll_zero) poll_pend_q <= 1'b1;
            end else begin
              target_mouse_q <= ~target_mouse_q;
              poll_pend_q    <= 1'b0;
              srq_pend_q     <= 1'b0;
            end
          end
        end
        S_CMD: begin
          if (settle_zero) begin
            state_q      <= cmd_nxt;
            st_q         <= (cmd_nxt == S_DONE) ? ST_IDLE : ST_EVEN;
            via_busy_q   <= 1'b0;
            resp_valid_q <= (cmd_nxt == S_DONE);
            got_q        <= 1'b0;
          end
        end
        S_EVEN, S_ODD: begin
`ifdef ADB_SRQ_POLL_EN
          if (!resp_host_q && !_int) srq_pend_q <= 1'b1;
`endif
          if (cap) begin
            if (state_q == S_EVEN) resp_data_q[15:8] <= adb_dout;
            else                   resp_data_q[7:0]  <= adb_dout;
            resp_len_q <= resp_len_q + 2'd1;
            got_q      <= 1'b1;
          end else if (got_q && settle_zero) begin
            if (state_q == S_EVEN && op_q[3:2] == OP_TALK) begin
              state_q <= S_ODD;
              st_q    <= ST_ODD;
              got_q   <= 1'b0;
            end else begin
              state_q      <= S_DONE;
              st_q         <= ST_IDLE;
              resp_valid_q <= 1'b1;
            end
          end else if (!got_q && to_zero) begin
            state_q        <= S_DONE;
            st_q           <= ST_IDLE;
            resp_valid_q   <= 1'b1;
            resp_timeout_q <= 1'b1;
          end
        end
        S_LEVEN, S_LODD: begin
          if (!got_q) begin
            adb_din_q        <= (state_q == S_LEVEN) ? data_q[15:8] : data_q[7:0];
            adb_din_strobe_q <= 1'b1;
            got_q            <= 1'b1;
          end else if (settle_zero) begin
            if (state_q == S_LEVEN) begin
              state_q <= S_LODD;
              st_q    <= ST_ODD;
              got_q   <= 1'b0;
            end else begin
              state_q      <= S_DONE;
              st_q         <= ST_IDLE;
              resp_valid_q <= 1'b1;
            end
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifndef ADB_SRQ_POLL_EN
  logic unused_int;
  assign unused_int = _int;
`endif

  assign st             = st_q;
  assign viaBusy        = via_busy_q;
  assign adb_din        = adb_din_q;
  assign adb_din_strobe = adb_din_strobe_q;
  assign host_ack       = host_ack_q;
  assign resp_valid     = resp_valid_q;
  assign resp_data      = resp_data_q;
  assign resp_len       = resp_len_q;
  assign resp_host      = resp_host_q;
  assign resp_timeout   = resp_timeout_q;

endmodule

// File: doc/adb_host_sequencer.md
Name: adb_host_sequencer

Overview:
- Host-side ADB bus sequencer. Drives the ADB transceiver's state lines (st) and command/data bytes, and collects its response bytes.
- Arbitrates between two requesters:
  - an explicit host command port (CPU/debug), which has priority;
  - an internal autopoll scheduler issuing Talk R0 alternately to keyboard and mouse.
- Sits between the system controller and the ADB device model.
- All timing is counted in clk_en ticks, nominally 8 MHz.

Parameters:
- POLL_INTERVAL, 17'd88000: clk_en ticks between autopolls (11 ms).
- SETTLE, 8'd64: ticks st is held before advancing (command phase and after each byte).
- BYTE_TIMEOUT, 16'd800: ticks to wait for a response byte before aborting (100 us).
- ADDR_KBD, 4'd2: keyboard ADB address.
- ADDR_MOUSE, 4'd3: mouse ADB address.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- clk_en  in  1  tick enable; all state advances only when high
- st  out  2  ADB state to transceiver: 00 command, 01 even byte, 10 odd byte, 11 idle
- viaBusy  out  1  high only in CMD state
- adb_din  out  8  command or listen data byte
- adb_din_strobe  out  1  one-tick pulse qualifying adb_din
- adb_dout  in  8  response byte from transceiver
- adb_dout_strobe  in  1  response byte valid
- _int  in  1  active-low service request from transceiver
- host_req  in  1  host command pending (level)
- host_cmd  in  8  {addr[3:0], cmd[3:0]}
- host_data  in  16  Listen payload, high byte sent first
- host_ack  out  1  one-tick pulse: host command accepted
- resp_valid  out  1  one-tick pulse: transaction finished
- resp_data  out  16  received bytes {byte0, byte1}; 16'hFFFF for unreceived bytes
- resp_len  out  2  number of bytes received, 0..2
- resp_host  out  1  1 = result belongs to a host command, 0 = autopoll
- resp_timeout  out  1  transaction ended by BYTE_TIMEOUT

Behaviour:
- Reset values:
  - st=11, adb_din=0, viaBusy=0.
  - All strobes/pulses 0, resp_data=FFFF, resp_len=0.
  - Poll timer = POLL_INTERVAL; next autopoll target = keyboard.
  - State = IDLE.
- Reset mid-transaction aborts to IDLE with no resp_valid.
- IDLE (st=11):
  - Poll timer decrements each tick; it saturates at 0 and reloads on every transaction start.
  - host_req takes priority: latch host_cmd/host_data, pulse host_ack, go to CMD.
  - Otherwise, if timer==0: build command {target, 4'b1100}, toggle target, go to CMD.
  - host_req and timer expiry on the same tick: host wins; the autopoll stays pending for the next IDLE.
  - adb_dout_strobe received in IDLE (device idle 8'hFF) is ignored.
- CMD (st=00):
  - On the first tick: adb_din=command, adb_din_strobe=1 for exactly one tick.
  - Hold for SETTLE ticks, then decode cmd[3:0]:
    - 11rr (Talk), 0000 (Reset), 0001 (Flush) go to EVEN.
    - 10rr (Listen) goes to LEVEN.
    - Any other value goes to DONE.
- EVEN (st=01), then ODD (st=10):
  - Wait for adb_dout_strobe; capture the byte and increment resp_len.
  - Hold SETTLE ticks after capture, then advance.
  - Reset/Flush: end after EVEN.
  - BYTE_TIMEOUT expiry (counter reloads on each state entry) goes to DONE with resp_timeout=1.
- LEVEN (st=01), then LODD (st=10):
  - Pulse adb_din_strobe with host_data[15:8], then with host_data[7:0].
  - Each pulse occurs on the tick after entry; hold SETTLE ticks after each.
  - resp_len stays 0.
- DONE (st=11):
  - Pulse resp_valid for one tick; resp_* stay stable until the next transaction starts.
  - Return to IDLE.
- Strobe widths are one tick; with clk_en low, pulses stretch until the next clk_en tick.
- resp_len never exceeds 2. Extra dout strobes in any state other than EVEN/ODD are dropped.

Optional Feature:
- Macro: ADB_SRQ_POLL_EN.
- Defined:
  - _int sampled low during EVEN/ODD of an autopoll sets srq_pend.
  - In IDLE, srq_pend forces the poll timer to 0, so the other device is polled immediately. Host priority still applies.
  - srq_pend clears when that poll starts.
- Undefined: _int is ignored; polling is purely interval-driven.

Decomposition:
- adb_pkg holds:
  - st encodings (ST_CMD, ST_EVEN, ST_ODD, ST_IDLE);
  - opcode constants (OP_RESET=4'b0000, OP_FLUSH=4'b0001, OP_LISTEN=2'b10, OP_TALK=2'b11);
  - the sequencer state enum.
- One sub-module, adb_tick_timer: loadable down-counter with a zero flag, gated by clk_en. Used for SETTLE, BYTE_TIMEOUT and the poll interval (three instances).

Test Plan:
- Idle, no host activity:
  - After 88000 ticks: command 8'h2C strobed with st=00.
  - Device returns FF,FF: resp_valid, resp_len=2, resp_data=FFFF, resp_host=0.
  - The next poll issues 8'h3C.
- Host Talk R3 to mouse (host_cmd=8'h3F): host_ack within one tick; device returns 63,01; resp_data=6301, resp_len=2, resp_host=1.
- Host Listen R2 to keyboard (host_cmd=8'h2A, host_data=16'h0005):
  - strobes 2A (st=00), 00 (st=01), 05 (st=10);
  - resp_len=0, no timeout.
- Talk to absent address 8'h5C: no dout strobe; after 800 ticks in EVEN, resp_timeout=1, resp_len=0, resp_data=FFFF.
- host_req asserted on the same tick the poll timer reaches 0: host command issued first, autopoll immediately after; reset asserted mid-ODD returns st=11 and produces no resp_valid.
- With ADB_SRQ_POLL_EN: _int=0 during the keyboard poll leads to 8'h3C being issued right after DONE, without waiting 88000 ticks.
